// File: rtl/l2_arb_pkg.sv
// Shared types and address-field geometry for the two-core L2 bus arbiter.
package l2_arb_pkg;

  localparam int ADDR_W   = 15;
  localparam int TAG_W    = 5;
  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    OWN0     = 2'd1,
    OWN1     = 2'd2,
    RELEASE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sat_counter8.sv
// 8-bit event counter that sticks at 8'hFF instead of wrapping.
module sat_counter8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  output logic [7:0] o_count
);

  logic [7:0] r_count;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (i_en && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/l2_bus_arbiter.sv
// Two-core L2 bus arbiter: round-robin on conflict, one-cycle release gap,
// snoop broadcast to the non-owning core and saturating usage statistics.
module l2_bus_arbiter
  import l2_arb_pkg::*;
#(
  parameter int n       = 32,
  parameter int tag_w   = TAG_W,
  parameter int index_w = INDEX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               c0_read_request,
  input  logic               c1_read_request,
  input  logic               c0_write_request,
  input  logic               c1_write_request,
  input  logic [ADDR_W-1:0]  c0_word_address,
  input  logic [ADDR_W-1:0]  c1_word_address,
  input  logic [n-1:0]       c0_write_word,
  input  logic [n-1:0]       c1_write_word,
  output logic [n-1:0]       c0_read_word,
  output logic [n-1:0]       c1_read_word,
  output logic               c0_L2_busy,
  output logic               c1_L2_busy,
  output logic               c0_others_read_request,
  output logic               c0_others_write_request,
  output logic               c1_others_read_request,
  output logic               c1_others_write_request,
  output logic [tag_w-1:0]   c0_others_block_tag,
  output logic [tag_w-1:0]   c1_others_block_tag,
  output logic [index_w-1:0] c0_others_block_index,
  output logic [index_w-1:0] c1_others_block_index,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [n-1:0]       mem_wdata,
  output logic               mem_re,
  output logic               mem_we,
  input  logic [n-1:0]       mem_rdata,
  input  logic               mem_busy,
  output logic [31:0]        arb_statistics
);

  arb_state_t r_state, w_state_next;
  logic       r_last_grant, w_last_grant_next;
  logic       w_conflict;
  logic       w_req0, w_req1, w_grant0, w_grant1, w_adv;
  logic [n-1:0] r_read_word0, r_read_word1;
  logic [7:0] w_grant0_cnt, w_grant1_cnt, w_conflict_cnt, w_snoop_cnt;

  assign w_req0   = c0_read_request | c0_write_request;
  assign w_req1   = c1_read_request | c1_write_request;
  assign w_grant0 = (r_state == OWN0);
  assign w_grant1 = (r_state == OWN1);
  assign w_adv    = ~mem_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= 1'b1;
    end else if (w_adv) begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
    end
  end

  // NOTE: every variable driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    w_conflict        = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_req0 && w_req1) begin
          w_conflict        = 1'b1;
          w_state_next      = r_last_grant ? OWN0 : OWN1;
          w_last_grant_next = ~r_last_grant;
        end else if (w_req0) begin
          w_state_next = OWN0;
        end else if (w_req1) begin
          w_state_next = OWN1;
        end
      end
      OWN0:    if (!w_req0) w_state_next = RELEASE;
      OWN1:    if (!w_req1) w_state_next = RELEASE;
      RELEASE: w_state_next = ARB_IDLE;
      default: w_state_next = ARB_IDLE;
    endcase
  end

  // Reset gates the combinational outputs so they drop the instant reset falls.
  always_comb begin
    mem_address             = '0;
    mem_wdata               = '0;
    mem_re                  = 1'b0;
    mem_we                  = 1'b0;
    c0_L2_busy              = 1'b0;
    c1_L2_busy              = 1'b0;
    c0_others_read_request  = 1'b0;
    c0_others_write_request = 1'b0;
    c1_others_read_request  = 1'b0;
    c1_others_write_request = 1'b0;
    c0_others_block_tag     = '0;
    c0_others_block_index   = '0;
    c1_others_block_tag     = '0;
    c1_others_block_index   = '0;
    if (reset) begin
      c0_L2_busy = w_grant0 ? mem_busy : w_req0;
      c1_L2_busy = w_grant1 ? mem_busy : w_req1;
      case (r_state)
        OWN0: begin
          mem_address             = c0_word_address;
          mem_wdata               = c0_write_word;
          mem_re                  = c0_read_request;
          mem_we                  = c0_write_request & ~c0_read_request;
          c1_others_read_request  = c0_read_request;
          c1_others_write_request = c0_write_request;
          c1_others_block_tag     = c0_word_address[ADDR_W-1 -: tag_w];
          c1_others_block_index   = c0_word_address[OFFSET_W +: index_w];
        end
        OWN1: begin
          mem_address             = c1_word_address;
          mem_wdata               = c1_write_word;
          mem_re                  = c1_read_request;
          mem_we                  = c1_write_request & ~c1_read_request;
          c0_others_read_request  = c1_read_request;
          c0_others_write_request = c1_write_request;
          c0_others_block_tag     = c1_word_address[ADDR_W-1 -: tag_w];
          c0_others_block_index   = c1_word_address[OFFSET_W +: index_w];
        end
        default: ;
      endcase
    end
  end

  // Both read-word registers track the bus; only the unfrozen L1 consumes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_read_word0 <= '0;
      r_read_word1 <= '0;
    end else if (w_adv) begin
      r_read_word0 <= mem_rdata;
      r_read_word1 <= mem_rdata;
    end
  end

  assign c0_read_word = r_read_word0;
  assign c1_read_word = r_read_word1;

  sat_counter8 u_grant0_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .i_en    (w_adv && (r_state == ARB_IDLE) && (w_state_next == OWN0)),
    .o_count (w_grant0_cnt)
  );

  sat_counter8 u_grant1_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .i_en    (w_adv && (r_state == ARB_IDLE) && (w_state_next == OWN1)),
    .o_count (w_grant1_cnt)
  );

  sat_counter8 u_conflict_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .i_en    (w_adv && w_conflict),
    .o_count (w_conflict_cnt)
  );

  sat_counter8 u_snoop_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .i_en    (w_adv && ((w_grant0 && c0_write_request) || (w_grant1 && c1_write_request))),
    .o_count (w_snoop_cnt)
  );

  assign arb_statistics = {w_grant0_cnt, w_grant1_cnt, w_conflict_cnt, w_snoop_cnt};

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Self-checking bench for l2_bus_arbiter: a vector table for arbitration and
// snoop behaviour, hand sequences for stall/reset/saturation, read-data queue.
module tb_l2_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        c0_read_request, c1_read_request;
  logic        c0_write_request, c1_write_request;
  logic [14:0] c0_word_address, c1_word_address;
  logic [31:0] c0_write_word, c1_write_word;
  logic [31:0] c0_read_word, c1_read_word;
  logic        c0_L2_busy, c1_L2_busy;
  logic        c0_others_read_request, c0_others_write_request;
  logic        c1_others_read_request, c1_others_write_request;
  logic [4:0]  c0_others_block_tag, c1_others_block_tag;
  logic [5:0]  c0_others_block_index, c1_others_block_index;
  logic [14:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic [31:0] arb_statistics;

  l2_bus_arbiter dut (
    .clk                     (clk),
    .reset                   (reset),
    .c0_read_request         (c0_read_request),
    .c1_read_request         (c1_read_request),
    .c0_write_request        (c0_write_request),
    .c1_write_request        (c1_write_request),
    .c0_word_address         (c0_word_address),
    .c1_word_address         (c1_word_address),
    .c0_write_word           (c0_write_word),
    .c1_write_word           (c1_write_word),
    .c0_read_word            (c0_read_word),
    .c1_read_word            (c1_read_word),
    .c0_L2_busy              (c0_L2_busy),
    .c1_L2_busy              (c1_L2_busy),
    .c0_others_read_request  (c0_others_read_request),
    .c0_others_write_request (c0_others_write_request),
    .c1_others_read_request  (c1_others_read_request),
    .c1_others_write_request (c1_others_write_request),
    .c0_others_block_tag     (c0_others_block_tag),
    .c1_others_block_tag     (c1_others_block_tag),
    .c0_others_block_index   (c0_others_block_index),
    .c1_others_block_index   (c1_others_block_index),
    .mem_address             (mem_address),
    .mem_wdata               (mem_wdata),
    .mem_re                  (mem_re),
    .mem_we                  (mem_we),
    .mem_rdata               (mem_rdata),
    .mem_busy                (mem_busy),
    .arb_statistics          (arb_statistics)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;     // {rr0, wr0, rr1, wr1}
    logic [14:0] a0, a1;
    logic [31:0] d0, d1;
    logic [3:0]  eflags;  // {c0_L2_busy, c1_L2_busy, mem_re, mem_we}
    logic [14:0] eaddr;
    logic [31:0] ewd;
    logic [3:0]  esn;     // {c0_others_rd, c0_others_wr, c1_others_rd, c1_others_wr}
    logic [10:0] es0;     // {c0_others_block_tag, c0_others_block_index}
    logic [10:0] es1;     // {c1_others_block_tag, c1_others_block_index}
    logic [31:0] est;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] rw_q[$];
  logic [31:0] exp_rw   = 32'h0;
  logic [14:0] tmp_addr;
  vec_t        vecs[17];

  function automatic vec_t mkv(input logic [3:0] req, input logic [14:0] a0, input logic [14:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1, input logic [3:0] eflags,
                               input logic [14:0] eaddr, input logic [31:0] ewd, input logic [3:0] esn,
                               input logic [10:0] es0, input logic [10:0] es1, input logic [31:0] est);
    vec_t v;
    v.req = req; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.eflags = eflags; v.eaddr = eaddr; v.ewd = ewd; v.esn = esn;
    v.es0 = es0; v.es1 = es1; v.est = est;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Mid-cycle sample point; registered read data is compared with the queue.
  task automatic settle();
    #2;
    if (rw_q.size() > 0) exp_rw = rw_q.pop_front();
    check("c0_read_word", c0_read_word, exp_rw);
    check("c1_read_word", c1_read_word, exp_rw);
  endtask

  task automatic advance();
    if (!mem_busy && reset) rw_q.push_back(mem_rdata);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    c0_read_request = 1'b0; c0_write_request = 1'b0;
    c1_read_request = 1'b0; c1_write_request = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; mem_busy = 1'b0; mem_rdata = 32'h0;
    idle_in();
    c0_word_address = 15'h0; c1_word_address = 15'h0;
    c0_write_word = 32'h0; c1_write_word = 32'h0;

    vecs[0]  = mkv(4'b1010, 15'h0123, 15'h0456, 32'h11111111, 32'h22222222, 4'b1100, 15'h0, 32'h0, 4'b0000, 11'h0, 11'h0, 32'h00000000);
    vecs[1]  = mkv(4'b1010, 15'h0123, 15'h0456, 32'h11111111, 32'h22222222, 4'b0110, 15'h0123, 32'h11111111, 4'b0010, 11'h0, {5'h00, 6'h12}, 32'h01000100);
    vecs[2]  = mkv(4'b0010, 15'h0123, 15'h0456, 32'h11111111, 32'h22222222, 4'b0100, 15'h0123, 32'h11111111, 4'b0000, 11'h0, {5'h00, 6'h12}, 32'h01000100);
    vecs[3]  = mkv(4'b1010, 15'h0123, 15'h0456, 32'h11111111, 32'h22222222, 4'b1100, 15'h0, 32'h0, 4'b0000, 11'h0, 11'h0, 32'h01000100);
    vecs[4]  = mkv(4'b1010, 15'h0123, 15'h0456, 32'h11111111, 32'h22222222, 4'b1100, 15'h0, 32'h0, 4'b0000, 11'h0, 11'h0, 32'h01000100);
    vecs[5]  = mkv(4'b1010, 15'h0123, 15'h0456, 32'h11111111, 32'h22222222, 4'b1010, 15'h0456, 32'h22222222, 4'b1000, {5'h01, 6'h05}, 11'h0, 32'h01010200);
    vecs[6]  = mkv(4'b0000, 15'h0123, 15'h0456, 32'h11111111, 32'h22222222, 4'b0000, 15'h0456, 32'h22222222, 4'b0000, {5'h01, 6'h05}, 11'h0, 32'h01010200);
    vecs[7]  = mkv(4'b0000, 15'h0123, 15'h0456, 32'h11111111, 32'h22222222, 4'b0000, 15'h0, 32'h0, 4'b0000, 11'h0, 11'h0, 32'h01010200);
    vecs[8]  = mkv(4'b0001, 15'h0123, 15'h7FF3, 32'h11111111, 32'hDEADBEEF, 4'b0100, 15'h0, 32'h0, 4'b0000, 11'h0, 11'h0, 32'h01010200);
    vecs[9]  = mkv(4'b0001, 15'h0123, 15'h7FF3, 32'h11111111, 32'hDEADBEEF, 4'b0001, 15'h7FF3, 32'hDEADBEEF, 4'b0100, {5'h1F, 6'h3F}, 11'h0, 32'h01020200);
    vecs[10] = mkv(4'b0001, 15'h0123, 15'h7FF3, 32'h11111111, 32'hDEADBEEF, 4'b0001, 15'h7FF3, 32'hDEADBEEF, 4'b0100, {5'h1F, 6'h3F}, 11'h0, 32'h01020201);
    vecs[11] = mkv(4'b0000, 15'h0123, 15'h7FF3, 32'h11111111, 32'hDEADBEEF, 4'b0000, 15'h7FF3, 32'hDEADBEEF, 4'b0000, {5'h1F, 6'h3F}, 11'h0, 32'h01020202);
    vecs[12] = mkv(4'b0000, 15'h0123, 15'h7FF3, 32'h11111111, 32'hDEADBEEF, 4'b0000, 15'h0, 32'h0, 4'b0000, 11'h0, 11'h0, 32'h01020202);
    vecs[13] = mkv(4'b1100, 15'h0ABC, 15'h7FF3, 32'h12345678, 32'hDEADBEEF, 4'b1000, 15'h0, 32'h0, 4'b0000, 11'h0, 11'h0, 32'h01020202);
    vecs[14] = mkv(4'b1100, 15'h0ABC, 15'h7FF3, 32'h12345678, 32'hDEADBEEF, 4'b0010, 15'h0ABC, 32'h12345678, 4'b0011, 11'h0, {5'h02, 6'h2B}, 32'h02020202);
    vecs[15] = mkv(4'b0000, 15'h0ABC, 15'h7FF3, 32'h12345678, 32'hDEADBEEF, 4'b0000, 15'h0ABC, 32'h12345678, 4'b0000, 11'h0, {5'h02, 6'h2B}, 32'h02020203);
    vecs[16] = mkv(4'b0000, 15'h0ABC, 15'h7FF3, 32'h12345678, 32'hDEADBEEF, 4'b0000, 15'h0, 32'h0, 4'b0000, 11'h0, 11'h0, 32'h02020203);

    // Reset held: a request must not raise busy, everything reads zero.
    #12;
    c0_read_request = 1'b1;
    #1;
    check("rst busy0", {31'h0, c0_L2_busy}, 32'h0);
    check("rst mem_re", {31'h0, mem_re}, 32'h0);
    check("rst stats", arb_statistics, 32'h0);
    check("rst read_word0", c0_read_word, 32'h0);
    idle_in();
    @(posedge clk); #1;
    reset = 1'b1;
    settle();
    advance();

    // Arbitration, snoop and write-through table.
    for (int i = 0; i < 17; i++) begin
      {c0_read_request, c0_write_request, c1_read_request, c1_write_request} = vecs[i].req;
      c0_word_address = vecs[i].a0; c1_word_address = vecs[i].a1;
      c0_write_word   = vecs[i].d0; c1_write_word   = vecs[i].d1;
      mem_rdata       = 32'hA000_0000 + 32'(i);
      settle();
      check($sformatf("v%0d flags", i), {28'h0, c0_L2_busy, c1_L2_busy, mem_re, mem_we}, {28'h0, vecs[i].eflags});
      check($sformatf("v%0d mem_address", i), {17'h0, mem_address}, {17'h0, vecs[i].eaddr});
      check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].ewd);
      check($sformatf("v%0d snoop_req", i),
            {28'h0, c0_others_read_request, c0_others_write_request, c1_others_read_request, c1_others_write_request},
            {28'h0, vecs[i].esn});
      check($sformatf("v%0d snoop0_tagidx", i), {21'h0, c0_others_block_tag, c0_others_block_index}, {21'h0, vecs[i].es0});
      check($sformatf("v%0d snoop1_tagidx", i), {21'h0, c1_others_block_tag, c1_others_block_index}, {21'h0, vecs[i].es1});
      check($sformatf("v%0d stats", i), arb_statistics, vecs[i].est);
      advance();
    end
    idle_in();

    // Core 0 streaming reads: read_word lags the bus by one cycle.
    c0_read_request = 1'b1;
    for (int k = 0; k < 18; k++) begin
      tmp_addr = 15'h0400 + 15'(k % 16);
      c0_word_address = tmp_addr;
      mem_rdata = {17'h0, tmp_addr};
      settle();
      if (k == 0) begin
        check("rd idle busy0", {31'h0, c0_L2_busy}, 32'h1);
      end else begin
        check($sformatf("rd%0d busy0", k), {31'h0, c0_L2_busy}, 32'h0);
        check($sformatf("rd%0d mem_re", k), {31'h0, mem_re}, 32'h1);
        check($sformatf("rd%0d mem_address", k), {17'h0, mem_address}, {17'h0, tmp_addr});
        check($sformatf("rd%0d c1_snoop", k), {20'h0, c1_others_read_request, c1_others_block_tag, c1_others_block_index},
              {20'h0, 1'b1, 5'h01, 6'h00});
      end
      advance();
    end
    c0_read_request = 1'b0;
    settle(); advance();
    settle();
    check("rd stats", arb_statistics, 32'h03020203);
    advance();

    // mem_busy freezes arbitration in ARB_IDLE and then mid-tenure in OWN0.
    c0_read_request = 1'b1; c0_word_address = 15'h0200;
    mem_busy = 1'b1; mem_rdata = 32'hBAD0_0000;
    settle();
    check("stall idle busy0", {31'h0, c0_L2_busy}, 32'h1);
    advance();
    mem_busy = 1'b0; mem_rdata = 32'h1111_0001;
    settle();
    check("stall held idle mem_re", {31'h0, mem_re}, 32'h0);
    advance();
    mem_rdata = 32'h1111_0002;
    settle();
    check("stall own busy0", {31'h0, c0_L2_busy}, 32'h0);
    check("stall own stats", arb_statistics, 32'h04020203);
    advance();
    mem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_rdata = 32'hBAD0_0003 + 32'(k);
      settle();
      check($sformatf("stall%0d busy0", k), {31'h0, c0_L2_busy}, 32'h1);
      check($sformatf("stall%0d mem_address", k), {17'h0, mem_address}, 32'h0200);
      check($sformatf("stall%0d stats", k), arb_statistics, 32'h04020203);
      advance();
    end
    mem_busy = 1'b0; mem_rdata = 32'h1111_0006;
    settle();
    check("stall end busy0", {31'h0, c0_L2_busy}, 32'h0);
    check("stall end mem_re", {31'h0, mem_re}, 32'h1);
    advance();
    idle_in(); mem_rdata = 32'h0;
    settle(); advance();
    settle(); advance();

    // Asynchronous reset in the middle of a core-1 tenure.
    c1_read_request = 1'b1; c1_word_address = 15'h1234;
    settle(); advance();
    c0_read_request = 1'b1; c0_word_address = 15'h0155;
    settle();
    check("own1 mem_re", {31'h0, mem_re}, 32'h1);
    check("own1 busy0", {31'h0, c0_L2_busy}, 32'h1);
    #1;
    reset = 1'b0;
    #1;
    check("arst mem_re", {31'h0, mem_re}, 32'h0);
    check("arst mem_we", {31'h0, mem_we}, 32'h0);
    check("arst busy", {30'h0, c0_L2_busy, c1_L2_busy}, 32'h0);
    check("arst snoop", {30'h0, c0_others_read_request, c1_others_read_request}, 32'h0);
    check("arst read_word1", c1_read_word, 32'h0);
    check("arst stats", arb_statistics, 32'h0);
    rw_q.delete();
    exp_rw = 32'h0;
    @(posedge clk); #1;
    reset = 1'b1;
    settle();
    check("post-rst conflict busy", {30'h0, c0_L2_busy, c1_L2_busy}, 32'h3);
    advance();
    c1_read_request = 1'b0;
    settle();
    check("post-rst busy0", {31'h0, c0_L2_busy}, 32'h0);
    check("post-rst mem_address", {17'h0, mem_address}, 32'h0155);
    check("post-rst stats", arb_statistics, 32'h01000100);
    advance();
    idle_in();
    settle(); advance();
    settle(); advance();

    // Grant counter saturation.
    for (int g = 0; g < 300; g++) begin
      c0_read_request = 1'b1;
      settle(); advance();
      c0_read_request = 1'b0;
      settle(); advance();
      settle(); advance();
    end
    settle();
    check("sat stats", arb_statistics, 32'hFF000100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
